sqrt_newton_raphson_fixedpoint: RTL and testbench



---
 rtl/sqrt_newton_raphson_fixedpoint.sv | 158 +++++++++++++++
 tb/tb_sqrt_newton_raphson_fixedpoint.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_newton_raphson_fixedpoint.sv
// Sequential unsigned fixed-point square root: integer Newton-Raphson on R = X << M,
// with each quotient R / y produced by a bit-serial restoring divider.
module sqrt_newton_raphson_fixedpoint #(
    parameter int N        = 16,
    parameter int M        = 8,
    parameter int ITER_MAX = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    output logic [N-1:0] sqrt_result,
    output logic         ready
);

    localparam int W   = N + M;
    localparam int DCW = $clog2(W);
    localparam int ICW = (ITER_MAX > 1) ? $clog2(ITER_MAX) : 1;
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(W - 1);
    localparam logic [ICW-1:0] ITER_LAST = ICW'(ITER_MAX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        DIV    = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Power of two at or above sqrt(r): 2^ceil(b/2), b = bit length of r.
    function automatic logic [W-1:0] initial_estimate(input logic [W-1:0] r);
        logic [DCW:0] b;
        b = '0;
        for (int i = 0; i < W; i++) begin
            b = r[i] ? (DCW + 1)'(i + 1) : b;
        end
        return W'(1) << ((b + (DCW + 1)'(1)) >> 1);
    endfunction

    state_t         state_r, state_s;
    logic [N-1:0]   x_r, x_s;
    logic [W-1:0]   y_r, y_s;
    logic [W-1:0]   q_r, q_s;
    logic [W-1:0]   rem_r, rem_s;
    logic [DCW-1:0] div_cnt_r, div_cnt_s;
    logic [ICW-1:0] iter_r, iter_s;
    logic [N-1:0]   result_r, result_s;
    logic           ready_r, ready_s;

    logic [W:0]     rem_shift_s;
    logic [W:0]     sum_s;
    logic [W-1:0]   y_next_s;

    assign sqrt_result = result_r;
    assign ready       = ready_r;

    // Next-state and datapath updates for the whole operation sequence.
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        y_s       = y_r;
        q_s       = q_r;
        rem_s     = rem_r;
        div_cnt_s = div_cnt_r;
        iter_s    = iter_r;
        result_s  = result_r;
        ready_s   = ready_r;

        // q_r doubles as the dividend shift register; its MSB feeds the partial remainder.
        rem_shift_s = {rem_r, q_r[W-1]};
        sum_s       = {1'b0, y_r} + {1'b0, q_r};
        y_next_s    = W'(sum_s >> 1);

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    x_s     = X;
                    ready_s = 1'b0;
                    state_s = INIT;
                end else begin
                    state_s = state_r;
                end
            end
            INIT: begin
                if (x_r == '0) begin
                    result_s = '0;
                    ready_s  = 1'b1;
                    state_s  = DONE;
                end else begin
                    y_s       = initial_estimate({x_r, {M{1'b0}}});
                    q_s       = {x_r, {M{1'b0}}};
                    rem_s     = '0;
                    div_cnt_s = '0;
                    iter_s    = '0;
                    state_s   = DIV;
                end
            end
            DIV: begin
                if (rem_shift_s >= {1'b0, y_r}) begin
                    rem_s = W'(rem_shift_s - {1'b0, y_r});
                    q_s   = {q_r[W-2:0], 1'b1};
                end else begin
                    rem_s = W'(rem_shift_s);
                    q_s   = {q_r[W-2:0], 1'b0};
                end
                if (div_cnt_r == DIV_LAST) begin
                    state_s = UPDATE;
                end else begin
                    div_cnt_s = div_cnt_r + DCW'(1);
                end
            end
            UPDATE: begin
                // A non-decreasing step means the descending sequence has bottomed out.
                if ((y_next_s >= y_r) || (iter_r == ITER_LAST)) begin
                    result_s = (y_next_s < y_r) ? y_next_s[N-1:0] : y_r[N-1:0];
                    ready_s  = 1'b1;
                    state_s  = DONE;
                end else begin
                    y_s       = y_next_s;
                    iter_s    = iter_r + ICW'(1);
                    q_s       = {x_r, {M{1'b0}}};
                    rem_s     = '0;
                    div_cnt_s = '0;
                    state_s   = DIV;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            q_r       <= '0;
            rem_r     <= '0;
            div_cnt_r <= '0;
            iter_r    <= '0;
            result_r  <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            y_r       <= y_s;
            q_r       <= q_s;
            rem_r     <= rem_s;
            div_cnt_r <= div_cnt_s;
            iter_r    <= iter_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
        end
    end

endmodule

// File: tb/tb_sqrt_newton_raphson_fixedpoint.sv
// Self-checking bench for sqrt_newton_raphson_fixedpoint: directed and random radicands
// compared against an exact integer square-root reference.
module tb_sqrt_newton_raphson_fixedpoint;

    localparam int N        = 16;
    localparam int M        = 8;
    localparam int ITER_MAX = 10;
    localparam int LAT_MAX  = 2 + ITER_MAX * (N + M + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] sqrt_result;
    logic         ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sqrt_newton_raphson_fixedpoint #(.N(N), .M(M), .ITER_MAX(ITER_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .X           (X),
        .sqrt_result (sqrt_result),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    // Exact floor(sqrt(x * 2^M)) by plain search.
    function automatic int ref_sqrt(input int x);
        longint r;
        longint s;
        r = longint'(x) << M;
        s = 0;
        while ((s + 1) * (s + 1) <= r) s++;
        return int'(s);
    endfunction

    // Present X with a one-cycle start pulse; returns at the negedge after the accepting edge.
    task automatic issue(input logic [N-1:0] v);
        @(negedge clk);
        X     = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < LAT_MAX + 5) begin
            @(negedge clk);
            cyc++;
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; X = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", ready);
        else pass_cnt++;
        total_cnt++;
        if (sqrt_result !== '0) $display("FAIL reset_result: got %0d expected 0", sqrt_result);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int cyc; bit ok;
        issue(16'd0);
        wait_ready(cyc, ok);
        total_cnt++;
        if (!ok || cyc > 2) $display("FAIL zero_latency: got %0d cycles (ok=%0b) expected <=2", cyc, ok);
        else pass_cnt++;
        total_cnt++;
        if (sqrt_result !== 16'd0) $display("FAIL zero_result: got %0d expected 0", sqrt_result);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        logic [N-1:0] xs  [10] = '{16'd256, 16'd1024, 16'd16, 16'd64, 16'd1,
                                   16'd2, 16'd100, 16'd300, 16'hFFFF, 16'd4095};
        logic [N-1:0] exp [10] = '{16'd256, 16'd512, 16'd64, 16'd128, 16'd16,
                                   16'd22, 16'd160, 16'd277, 16'd4095, 16'd1023};
        int cyc; bit ok;
        for (int i = 0; i < 10; i++) begin
            issue(xs[i]);
            total_cnt++;
            if (ready !== 1'b0) $display("FAIL directed_ready_clear X=%0d: got %0b expected 0", xs[i], ready);
            else pass_cnt++;
            wait_ready(cyc, ok);
            total_cnt++;
            if (!ok || cyc > LAT_MAX) $display("FAIL directed_latency X=%0d: got %0d cycles (ok=%0b) expected <=%0d", xs[i], cyc, ok, LAT_MAX);
            else pass_cnt++;
            total_cnt++;
            if (sqrt_result !== exp[i]) $display("FAIL directed X=%0d: got %0d expected %0d", xs[i], sqrt_result, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        int cyc; bit ok;
        int v;
        for (int k = 0; k < 61; k++) begin
            v = (k <= 40) ? 123 * (k + 9) : int'($urandom_range(65535, 1));
            issue(N'(v));
            X = N'($urandom);
            wait_ready(cyc, ok);
            total_cnt++;
            if (!ok || sqrt_result !== N'(ref_sqrt(v)))
                $display("FAIL random X=%0d: got %0d (ok=%0b) expected %0d", v, sqrt_result, ok, ref_sqrt(v));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit ok;
        issue(16'hFFFF);
        repeat (6) @(negedge clk);
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL busy_ready: got %0b expected 0", ready);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ready !== 1'b0 || sqrt_result !== '0)
            $display("FAIL reset_mid: got ready=%0b result=%0d expected ready=0 result=0", ready, sqrt_result);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        issue(16'd1024);
        wait_ready(cyc, ok);
        total_cnt++;
        if (!ok || sqrt_result !== 16'd512) $display("FAIL after_reset: got %0d (ok=%0b) expected 512", sqrt_result, ok);
        else pass_cnt++;
    endtask

    task automatic test_busy_start;
        int cyc; bit ok;
        issue(16'd1024);
        repeat (5) @(negedge clk);
        X     = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL busy_start_ready: got %0b expected 0", ready);
        else pass_cnt++;
        wait_ready(cyc, ok);
        total_cnt++;
        if (!ok || sqrt_result !== 16'd512) $display("FAIL busy_start: got %0d (ok=%0b) expected 512", sqrt_result, ok);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int cyc; bit ok;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL done_hold: got %0b expected 1", ready);
        else pass_cnt++;
        issue(16'd300);
        total_cnt++;
        if (ready !== 1'b0 || sqrt_result !== 16'd512)
            $display("FAIL b2b_accept: got ready=%0b result=%0d expected ready=0 result=512", ready, sqrt_result);
        else pass_cnt++;
        wait_ready(cyc, ok);
        total_cnt++;
        if (!ok || sqrt_result !== 16'd277) $display("FAIL b2b_first: got %0d (ok=%0b) expected 277", sqrt_result, ok);
        else pass_cnt++;
        issue(16'hFFFF);
        wait_ready(cyc, ok);
        total_cnt++;
        if (!ok || sqrt_result !== 16'd4095) $display("FAIL b2b_second: got %0d (ok=%0b) expected 4095", sqrt_result, ok);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_zero;
        test_directed;
        test_random;
        test_reset_mid;
        test_busy_start;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
